// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: LM/SM sequencer states, opcodes and default widths.
package pipeline_pkg;

    localparam int unsigned AW_DEF   = 16;
    localparam int unsigned DW_DEF   = 16;
    localparam int unsigned NREG_DEF = 8;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_DONE = 2'b10
    } lmsm_state_t;

endpackage

// File: rtl/lowest_set_enc.sv
// Priority encoder: index of the lowest set bit of vec, with a valid flag.
module lowest_set_enc #(
    parameter  int unsigned N  = 8,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lmsm_seq.sv
// Load-Multiple / Store-Multiple sequencer: one data-memory access per mask bit,
// ascending register index and address, pipeline stalled until done.
module lmsm_seq
    import pipeline_pkg::*;
#(
    parameter  int unsigned AW   = AW_DEF,
    parameter  int unsigned DW   = DW_DEF,
    parameter  int unsigned NREG = NREG_DEF,
    localparam int unsigned RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_sm,
    input  logic [AW-1:0]   base_addr,
    input  logic [NREG-1:0] reg_mask,
    input  logic            flush,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_read,
    output logic            mem_write,
    output logic [DW-1:0]   mem_din,
    input  logic [DW-1:0]   mem_dout,
    output logic [RW-1:0]   rf_rd_addr,
    input  logic [DW-1:0]   rf_rd_data,
    output logic            rf_wr_en,
    output logic [RW-1:0]   rf_wr_addr,
    output logic [DW-1:0]   rf_wr_data,
    output logic            stall,
    output logic            done
);

    lmsm_state_t     state_q, state_d;
    logic [AW-1:0]   addr_q;
    logic [NREG-1:0] mask_q;
    logic [NREG-1:0] mask_clr;
    logic            op_q;
    logic [RW-1:0]   idx;
    logic            idx_vld;
    logic            accept;
    logic            xfer_go;

    lowest_set_enc #(.N(NREG)) u_enc (
        .vec   (mask_q),
        .idx   (idx),
        .valid (idx_vld)
    );

    assign mask_clr = mask_q & ~(NREG'(1) << idx);
    assign accept   = (state_q == ST_IDLE) && start && (reg_mask != '0);
    assign xfer_go  = (state_q == ST_XFER) && idx_vld;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (reg_mask != '0) ? ST_XFER : ST_DONE;
                end
            end
            ST_XFER: begin
                if (!idx_vld || (mask_clr == '0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // Sequence context: address pointer, remaining mask and operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            mask_q <= '0;
            op_q   <= 1'b0;
        end else if (flush) begin
            mask_q <= '0;
        end else if (accept) begin
            addr_q <= base_addr;
            mask_q <= reg_mask;
            op_q   <= is_sm;
        end else if (xfer_go) begin
            addr_q <= addr_q + AW'(1);
            mask_q <= mask_clr;
        end
    end

    // Output decode: memory and register-file strobes only while transferring.
    always_comb begin
        mem_addr   = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_din    = '0;
        rf_rd_addr = '0;
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        stall      = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: stall = start;
            ST_XFER: begin
                stall = 1'b1;
                if (xfer_go) begin
                    mem_addr = addr_q;
                    if (op_q) begin
                        mem_write  = 1'b1;
                        rf_rd_addr = idx;
                        mem_din    = rf_rd_data;
                    end else begin
                        mem_read   = 1'b1;
                        rf_wr_en   = 1'b1;
                        rf_wr_addr = idx;
                        rf_wr_data = mem_dout;
                    end
                end
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lmsm_seq.sv
// Bench for lmsm_seq: bench-side memory and register file, per-cycle checks
// against an expected access list derived from the mask, and final-state checks.
module tb_lmsm_seq;

    logic        clk, rst, start, is_sm, flush;
    logic [15:0] base_addr;
    logic [7:0]  reg_mask;
    logic [15:0] mem_addr, mem_din, mem_dout, rf_rd_data, rf_wr_data;
    logic        mem_read, mem_write, rf_wr_en, stall, done;
    logic [2:0]  rf_rd_addr, rf_wr_addr;

    logic [15:0] mem [0:65535];
    logic [15:0] rf [8];
    int tests = 0;
    int fails = 0;
    int accesses = 0;

    assign mem_dout   = mem[mem_addr];
    assign rf_rd_data = rf[rf_rd_addr];

    lmsm_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_sm      (is_sm),
        .base_addr  (base_addr),
        .reg_mask   (reg_mask),
        .flush      (flush),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .stall      (stall),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [26:0] pack(input logic r, input logic w, input logic we,
                                         input logic st, input logic dn, input logic [15:0] a,
                                         input logic [2:0] ra, input logic [2:0] wa);
        return {r, w, we, st, dn, a, ra, wa};
    endfunction

    function automatic logic [26:0] obs();
        return pack(mem_read, mem_write, rf_wr_en, stall, done, mem_addr, rf_rd_addr, rf_wr_addr);
    endfunction

    // Memory and register file take the write presented this cycle.
    task automatic commit();
        if (mem_write) mem[mem_addr] = mem_din;
        if (rf_wr_en) rf[rf_wr_addr] = rf_wr_data;
        if (mem_read || mem_write) accesses++;
    endtask

    // kind: 0 = run to completion, 1 = flush during access number abort_at,
    // 2 = rst mid-cycle after abort_at accesses. busy drives a stray start during XFER.
    task automatic run_seq(input logic sm, input logic [15:0] base, input logic [7:0] mask,
                           input int abort_at, input int kind, input logic busy);
        int          regs[$];
        int          n, n_do;
        logic [15:0] a;
        logic [15:0] exp_rf [8];
        logic [15:0] exp_mem [logic [15:0]];
        logic [26:0] exp;
        logic        ended;

        regs = {};
        for (int i = 0; i < 8; i++) if (mask[i]) regs.push_back(i);
        n    = regs.size();
        n_do = (kind != 0 && abort_at < n) ? abort_at : n;

        exp_rf = rf;
        for (int k = 0; k < n_do; k++) begin
            a = base + 16'(k);
            if (sm) exp_mem[a] = rf[regs[k]];
            else exp_rf[regs[k]] = mem[a];
        end
        if (n_do < n) begin
            a = base + 16'(n_do);
            exp_mem[a] = mem[a];
        end
        accesses = 0;
        ended = 1'b0;

        @(negedge clk);
        start = 1'b1; is_sm = sm; base_addr = base; reg_mask = mask;
        #1;
        tests++;
        exp = pack(0, 0, 0, 1, 0, 16'h0, 3'd0, 3'd0);
        if (obs() !== exp) begin
            fails++;
            $display("FAIL accept_cycle: got %h expected %h", obs(), exp);
        end
        commit();

        for (int k = 0; k < n && !ended; k++) begin
            @(negedge clk);
            if (busy) begin
                start = 1'b1; is_sm = ~sm; base_addr = ~base; reg_mask = 8'h81;
            end else begin
                start = 1'b0;
            end
            if (kind == 2 && k == abort_at) begin
                start = 1'b0;
                rst = 1'b1;
                #1;
                tests++;
                if (obs() !== 27'd0) begin
                    fails++;
                    $display("FAIL rst_async_outputs: got %h expected %h", obs(), 27'd0);
                end
                commit();
                @(negedge clk);
                rst = 1'b0;
                #1;
                tests++;
                if (obs() !== 27'd0) begin
                    fails++;
                    $display("FAIL after_rst_idle: got %h expected %h", obs(), 27'd0);
                end
                commit();
                ended = 1'b1;
            end else begin
                if (kind == 1 && k == abort_at - 1) flush = 1'b1;
                #1;
                a = base + 16'(k);
                exp = pack(!sm, sm, !sm, 1, 0, a, sm ? 3'(regs[k]) : 3'd0, sm ? 3'd0 : 3'(regs[k]));
                tests++;
                if (obs() !== exp) begin
                    fails++;
                    $display("FAIL xfer_ctrl k=%0d: got %h expected %h", k, obs(), exp);
                end
                tests++;
                if (sm ? (mem_din !== rf[regs[k]]) : (rf_wr_data !== mem[a])) begin
                    fails++;
                    $display("FAIL xfer_data k=%0d: got din=%h wdata=%h expected %h", k, mem_din,
                             rf_wr_data, sm ? rf[regs[k]] : mem[a]);
                end
                commit();
                if (kind == 1 && k == abort_at - 1) begin
                    @(negedge clk);
                    flush = 1'b0; start = 1'b0;
                    #1;
                    tests++;
                    if (obs() !== 27'd0) begin
                        fails++;
                        $display("FAIL after_flush_idle: got %h expected %h", obs(), 27'd0);
                    end
                    commit();
                    ended = 1'b1;
                end
            end
        end

        if (!ended) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            tests++;
            exp = pack(0, 0, 0, 0, 1, 16'h0, 3'd0, 3'd0);
            if (obs() !== exp) begin
                fails++;
                $display("FAIL done_cycle: got %h expected %h", obs(), exp);
            end
            commit();
        end

        tests++;
        if (accesses != n_do) begin
            fails++;
            $display("FAIL access_count: got %0d expected %0d", accesses, n_do);
        end
        tests++;
        if (rf !== exp_rf) begin
            fails++;
            $display("FAIL rf_final: got %h %h %h %h %h %h %h %h", rf[0], rf[1], rf[2], rf[3],
                     rf[4], rf[5], rf[6], rf[7]);
        end
        foreach (exp_mem[ad]) begin
            tests++;
            if (mem[ad] !== exp_mem[ad]) begin
                fails++;
                $display("FAIL mem_final @%h: got %h expected %h", ad, mem[ad], exp_mem[ad]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; is_sm = 1'b0;
        base_addr = 16'h0; reg_mask = 8'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (obs() !== 27'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected %h", obs(), 27'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (obs() !== 27'd0) begin
            fails++;
            $display("FAIL idle_after_reset: got %h expected %h", obs(), 27'd0);
        end
    endtask

    task automatic test_lm_basic();
        mem[16'h0010] = 16'hAAAA;
        mem[16'h0011] = 16'h5555;
        run_seq(1'b0, 16'h0010, 8'b0000_0101, 0, 0, 1'b0);
        tests++;
        if (rf[0] !== 16'hAAAA || rf[2] !== 16'h5555) begin
            fails++;
            $display("FAIL lm_basic_regs: got R0=%h R2=%h expected AAAA 5555", rf[0], rf[2]);
        end
    endtask

    task automatic test_sm_all();
        for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
        run_seq(1'b1, 16'h0100, 8'hFF, 0, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (mem[16'h0100 + 16'(i)] !== 16'h1000 + 16'(i)) begin
                fails++;
                $display("FAIL sm_all_mem[%0d]: got %h expected %h", i, mem[16'h0100 + 16'(i)],
                         16'h1000 + 16'(i));
            end
        end
    endtask

    task automatic test_zero_mask();
        run_seq(1'b0, 16'h1234, 8'h00, 0, 0, 1'b0);
        run_seq(1'b1, 16'h4321, 8'h00, 0, 0, 1'b0);
    endtask

    task automatic test_wrap();
        mem[16'hFFFF] = 16'hBEEF;
        mem[16'h0000] = 16'hCAFE;
        run_seq(1'b0, 16'hFFFF, 8'b0000_0011, 0, 0, 1'b0);
        tests++;
        if (rf[0] !== 16'hBEEF || rf[1] !== 16'hCAFE) begin
            fails++;
            $display("FAIL wrap_regs: got R0=%h R1=%h expected BEEF CAFE", rf[0], rf[1]);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h0111 + 16'h0F00);
        run_seq(1'b1, 16'h0200, 8'hFF, 3, 1, 1'b0);
    endtask

    task automatic test_rst_abort();
        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
        run_seq(1'b1, 16'h0300, 8'hFF, 3, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) mem[16'h0400 + 16'(i)] = 16'($urandom);
        run_seq(1'b0, 16'h0400, 8'b1011_0010, 0, 0, 1'b1);
        run_seq(1'b1, 16'h0500, 8'b0110_0001, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] b;
        logic [7:0]  m;
        logic        s;
        for (int it = 0; it < 30; it++) begin
            s = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 16'hFFF8 + 16'($urandom_range(0, 7));
                default: b = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       m = 8'h00;
                1:       m = 8'hFF;
                default: m = 8'($urandom);
            endcase
            for (int i = 0; i < 8; i++) begin
                rf[i] = 16'($urandom);
                mem[b + 16'(i)] = 16'($urandom);
            end
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                start = 1'b0;
                #1;
                tests++;
                if (obs() !== 27'd0) begin
                    fails++;
                    $display("FAIL random_idle: got %h expected %h", obs(), 27'd0);
                end
            end
            run_seq(s, b, m, 0, 0, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_lm_basic();
        test_sm_all();
        test_zero_mask();
        test_wrap();
        test_flush();
        test_rst_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
